// File: rtl/blowfish_pkg.sv
// rtl/blowfish_pkg.sv - shared Blowfish key-setup constants and loader state type
package blowfish_pkg;

  localparam int WORD_W      = 32;
  localparam int P_DEPTH     = 18;
  localparam int SBOX_DEPTH  = 256;
  localparam int NUM_SBOX    = 4;
  localparam int TOTAL_WORDS = P_DEPTH + NUM_SBOX * SBOX_DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_P = 2'd1,
    ST_LOAD_S = 2'd2,
    ST_DONE   = 2'd3
  } load_state_e;

endpackage

// File: rtl/load_addr_gen.sv
// rtl/load_addr_gen.sv - index/S-box counter that addresses the P-array and S-box writes
module load_addr_gen #(
  parameter  int P_DEPTH    = 18,
  parameter  int SBOX_DEPTH = 256,
  parameter  int NUM_SBOX   = 4,
  localparam int PA_W       = $clog2(P_DEPTH),
  localparam int IDX_W      = $clog2(SBOX_DEPTH),
  localparam int SEL_W      = $clog2(NUM_SBOX)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                advance,
  input  logic                region_s,
  output logic [PA_W-1:0]     p_addr,
  output logic [IDX_W-1:0]    s_addr,
  output logic [NUM_SBOX-1:0] s_sel,
  output logic                p_last,
  output logic                s_last
);

  // The index is shared between regions: it counts P entries first, then
  // restarts at 0 for each S-box; P_DEPTH never exceeds SBOX_DEPTH.
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] sbox_q, sbox_d;
  logic             idx_wrap_s;

  assign p_addr     = idx_q[PA_W-1:0];
  assign s_addr     = idx_q;
  assign s_sel      = NUM_SBOX'(1) << sbox_q;
  assign idx_wrap_s = (idx_q == IDX_W'(SBOX_DEPTH - 1));
  assign p_last     = !region_s && (idx_q == IDX_W'(P_DEPTH - 1));
  assign s_last     = region_s && idx_wrap_s && (sbox_q == SEL_W'(NUM_SBOX - 1));

  // Next index: step on every accepted word, wrapping at region ends.
  always_comb begin
    idx_d  = idx_q;
    sbox_d = sbox_q;
    if (clear) begin
      idx_d  = '0;
      sbox_d = '0;
    end else if (advance) begin
      if (!region_s) begin
        idx_d = p_last ? '0 : idx_q + IDX_W'(1);
      end else if (idx_wrap_s) begin
        idx_d  = '0;
        sbox_d = sbox_q + SEL_W'(1);
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      sbox_q <= '0;
    end else begin
      idx_q  <= idx_d;
      sbox_q <= sbox_d;
    end
  end

endmodule

// File: rtl/sbox_loader.sv
// rtl/sbox_loader.sv - streams key-setup words into the P-array and the four S-box RAMs
module sbox_loader
  import blowfish_pkg::*;
#(
  parameter  int WORD_W_P     = WORD_W,
  parameter  int P_DEPTH_P    = P_DEPTH,
  parameter  int SBOX_DEPTH_P = SBOX_DEPTH,
  parameter  int NUM_SBOX_P   = NUM_SBOX,
  localparam int TOTAL        = P_DEPTH_P + NUM_SBOX_P * SBOX_DEPTH_P,
  localparam int PA_W         = $clog2(P_DEPTH_P),
  localparam int SA_W         = $clog2(SBOX_DEPTH_P),
  localparam int CNT_W        = $clog2(TOTAL + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_W_P-1:0]   din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  p_we,
  output logic [PA_W-1:0]       p_addr,
  output logic [WORD_W_P-1:0]   p_wdata,
  output logic [NUM_SBOX_P-1:0] s_we,
  output logic [SA_W-1:0]       s_addr,
  output logic [WORD_W_P-1:0]   s_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      word_cnt
);

  load_state_e           state_q, state_d;
  logic                  din_ready_q, din_ready_d;
  logic                  p_we_q, p_we_d;
  logic [PA_W-1:0]       p_addr_q, p_addr_d;
  logic [WORD_W_P-1:0]   p_wdata_q, p_wdata_d;
  logic [NUM_SBOX_P-1:0] s_we_q, s_we_d;
  logic [SA_W-1:0]       s_addr_q, s_addr_d;
  logic [WORD_W_P-1:0]   s_wdata_q, s_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;

  logic                  accept;
  logic                  gen_clear;
  logic [PA_W-1:0]       gen_p_addr;
  logic [SA_W-1:0]       gen_s_addr;
  logic [NUM_SBOX_P-1:0] gen_s_sel;
  logic                  gen_p_last;
  logic                  gen_s_last;

  // din_ready_q mirrors "state is LOAD_P or LOAD_S", so accepts only occur there.
  assign accept    = din_valid && din_ready_q;
  assign gen_clear = (state_q == ST_IDLE) && start;

  load_addr_gen #(
    .P_DEPTH    (P_DEPTH_P),
    .SBOX_DEPTH (SBOX_DEPTH_P),
    .NUM_SBOX   (NUM_SBOX_P)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (gen_clear),
    .advance  (accept),
    .region_s (state_q == ST_LOAD_S),
    .p_addr   (gen_p_addr),
    .s_addr   (gen_s_addr),
    .s_sel    (gen_s_sel),
    .p_last   (gen_p_last),
    .s_last   (gen_s_last)
  );

  // Sequencer and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    p_we_d     = 1'b0;
    p_addr_d   = p_addr_q;
    p_wdata_d  = p_wdata_q;
    s_we_d     = '0;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    done_d     = 1'b0;
    word_cnt_d = word_cnt_q;

    if (accept && (word_cnt_q != CNT_W'(TOTAL))) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD_P;
          word_cnt_d = '0;
        end
      end
      ST_LOAD_P: begin
        if (accept) begin
          p_we_d    = 1'b1;
          p_addr_d  = gen_p_addr;
          p_wdata_d = din;
          if (gen_p_last) state_d = ST_LOAD_S;
        end
      end
      ST_LOAD_S: begin
        if (accept) begin
          s_we_d    = gen_s_sel;
          s_addr_d  = gen_s_addr;
          s_wdata_d = din;
          if (gen_s_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    din_ready_d = (state_d == ST_LOAD_P) || (state_d == ST_LOAD_S);
    // done is registered one cycle after DONE, so busy stretches over it.
    busy_d      = (state_d != ST_IDLE) || (state_q == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      din_ready_q <= 1'b0;
      p_we_q      <= 1'b0;
      p_addr_q    <= '0;
      p_wdata_q   <= '0;
      s_we_q      <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      din_ready_q <= din_ready_d;
      p_we_q      <= p_we_d;
      p_addr_q    <= p_addr_d;
      p_wdata_q   <= p_wdata_d;
      s_we_q      <= s_we_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign din_ready = din_ready_q;
  assign p_we      = p_we_q;
  assign p_addr    = p_addr_q;
  assign p_wdata   = p_wdata_q;
  assign s_we      = s_we_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_sbox_loader.sv
// tb/tb_sbox_loader.sv - directed self-checking bench for sbox_loader
module tb_sbox_loader;
  import blowfish_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        p_we;
  logic [4:0]  p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  s_we;
  logic [7:0]  s_addr;
  logic [31:0] s_wdata;
  logic        busy;
  logic        done;
  logic [10:0] word_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // write monitor state
  bit mon_clear;
  int wr_idx;
  int seq_err;
  int excl_err;
  int region_cnt [5];
  int mon_j;

  sbox_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .p_we      (p_we),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .s_we      (s_we),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .busy      (busy),
    .done      (done),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_val(input int i);
    case (i)
      0:       return 32'h243f6a88;
      17:      return 32'h8979fb1b;
      18:      return 32'hd1310ba6;
      1041:    return 32'h3ac372e6;
      default: return (32'(i) * 32'h9e3779b9) ^ 32'h5a5aa5a5;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent model of the write sequence: every strobe is matched
  // against the expected region, address and data for its position.
  always @(negedge clk) begin
    if (mon_clear) begin
      wr_idx   = 0;
      seq_err  = 0;
      excl_err = 0;
      for (int k = 0; k < 5; k++) region_cnt[k] = 0;
    end else if (p_we || (s_we != 4'b0000)) begin
      if (p_we && (s_we != 4'b0000)) excl_err++;
      if ($countones(s_we) > 1) excl_err++;
      if (p_we) region_cnt[0]++;
      for (int k = 0; k < 4; k++) if (s_we[k]) region_cnt[k+1]++;
      if (wr_idx >= TOTAL_WORDS) begin
        seq_err++;
      end else if (wr_idx < 18) begin
        if (!p_we || p_addr != 5'(wr_idx) || p_wdata != word_val(wr_idx)) seq_err++;
      end else begin
        mon_j = wr_idx - 18;
        if (p_we || s_we != (4'b0001 << (mon_j / 256)) ||
            s_addr != 8'(mon_j % 256) || s_wdata != word_val(wr_idx)) seq_err++;
      end
      wr_idx++;
    end
  end

  task automatic check_all_zero(input string pfx);
    check({pfx, "_din_ready"}, din_ready, 0);
    check({pfx, "_p_we"},      p_we, 0);
    check({pfx, "_s_we"},      s_we, 0);
    check({pfx, "_busy"},      busy, 0);
    check({pfx, "_done"},      done, 0);
    check({pfx, "_p_addr"},    p_addr, 0);
    check({pfx, "_s_addr"},    s_addr, 0);
    check({pfx, "_p_wdata"},   p_wdata, 0);
    check({pfx, "_s_wdata"},   s_wdata, 0);
    check({pfx, "_word_cnt"},  word_cnt, 0);
  endtask

  task automatic begin_load();
    mon_clear = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mon_clear = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy",      busy, 1);
    check("start_din_ready", din_ready, 1);
  endtask

  task automatic directed_point(input int i);
    case (i)
      0: begin
        check("p0_we",    p_we, 1);
        check("p0_addr",  p_addr, 0);
        check("p0_data",  p_wdata, 32'h243f6a88);
        check("p0_s_we",  s_we, 0);
      end
      17: begin
        check("p17_we",   p_we, 1);
        check("p17_addr", p_addr, 17);
        check("p17_data", p_wdata, 32'h8979fb1b);
      end
      18: begin
        check("s0_0_we",   s_we, 4'b0001);
        check("s0_0_addr", s_addr, 0);
        check("s0_0_data", s_wdata, 32'hd1310ba6);
        check("s0_0_p_we", p_we, 0);
      end
      273: begin
        check("s0_255_we",   s_we, 4'b0001);
        check("s0_255_addr", s_addr, 255);
      end
      274: begin
        check("s1_0_we",   s_we, 4'b0010);
        check("s1_0_addr", s_addr, 0);
      end
      499: check("cnt_500", word_cnt, 500);
      default: ;
    endcase
  endtask

  task automatic run_load(input int n_words, input bit rnd, input bit poke_start, input bit directed);
    int  i     = 0;
    int  guard = 0;
    bit  acc;
    while (i < n_words && guard < 8000) begin
      din       = word_val(i);
      din_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = poke_start && (i == 600);
      acc       = din_valid && din_ready;
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (acc) begin
        if (directed) directed_point(i);
        i++;
      end
    end
    din_valid = 1'b0;
    if (i < n_words) check("load_stalled", i, n_words);
  endtask

  // Entered in the cycle right after the final accept.
  task automatic finish_checks(input bit poke_start);
    check("last_s_we",      s_we, 4'b1000);
    check("last_s_addr",    s_addr, 255);
    check("last_s_data",    s_wdata, 32'h3ac372e6);
    check("last_din_ready", din_ready, 0);
    check("last_done",      done, 0);
    check("last_busy",      busy, 1);
    start = poke_start;
    @(negedge clk);
    start = 1'b0;
    check("done_pulse",     done, 1);
    check("done_busy",      busy, 1);
    check("done_s_we",      s_we, 0);
    @(negedge clk);
    check("post_done",      done, 0);
    check("post_busy",      busy, 0);
    check("post_din_ready", din_ready, 0);
    check("post_word_cnt",  word_cnt, 1042);
  endtask

  task automatic mon_checks(input string pfx);
    check({pfx, "_writes"},   wr_idx, 1042);
    check({pfx, "_p_cnt"},    region_cnt[0], 18);
    check({pfx, "_s0_cnt"},   region_cnt[1], 256);
    check({pfx, "_s1_cnt"},   region_cnt[2], 256);
    check({pfx, "_s2_cnt"},   region_cnt[3], 256);
    check({pfx, "_s3_cnt"},   region_cnt[4], 256);
    check({pfx, "_seq_err"},  seq_err, 0);
    check({pfx, "_excl_err"}, excl_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    mon_clear = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // directed stream, start poked in LOAD_S and DONE
    begin_load();
    run_load(TOTAL_WORDS, 1'b0, 1'b1, 1'b1);
    finish_checks(1'b1);
    mon_checks("a");

    // random valid gaps
    begin_load();
    run_load(TOTAL_WORDS, 1'b1, 1'b0, 1'b0);
    finish_checks(1'b0);
    mon_checks("b");

    // reset mid-load then reload from P[0]
    begin_load();
    run_load(500, 1'b0, 1'b0, 1'b0);
    check("partial_cnt", word_cnt, 500);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst_busy", busy, 0);
    begin_load();
    run_load(TOTAL_WORDS, 1'b0, 1'b0, 1'b1);
    finish_checks(1'b0);
    mon_checks("c");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sbox_loader.md
# sbox_loader

Loads the Blowfish subkey memories: accepts a stream of 1042 32-bit words over a valid/ready handshake and issues write strobes into the 18-entry P-array and the four 256×32 S-box RAMs. It is the writer side of the S-box memories whose read side is the F-function lookup (`s1in` → `sr1out`). It runs once per key setup, before any encryption or decryption, and signals completion with a one-cycle `done` pulse.

## Interface
Parameters:
- `WORD_W`, 32, data word width
- `P_DEPTH`, 18, P-array entries
- `SBOX_DEPTH`, 256, entries per S-box
- `NUM_SBOX`, 4, number of S-boxes

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begins a load sequence; sampled only in IDLE
- `din`  in  32  word to store
- `din_valid`  in  1  `din` is valid
- `din_ready`  out  1  loader accepts `din` this cycle
- `p_we`  out  1  P-array write strobe
- `p_addr`  out  5  P-array address, 0..17
- `p_wdata`  out  32  P-array write data
- `s_we`  out  4  one-hot S-box write strobe; bit k selects S-box k
- `s_addr`  out  8  S-box address
- `s_wdata`  out  32  S-box write data
- `busy`  out  1  a load is in progress
- `done`  out  1  one-cycle pulse when the load is complete
- `word_cnt`  out  11  number of words accepted in the current or last load

## Operation
- States: IDLE, LOAD_P, LOAD_S, DONE.
- IDLE: `din_ready`=0. `start`=1 → LOAD_P, `word_cnt` cleared to 0.
- LOAD_P: `din_ready`=1. Each handshake (`din_valid`&&`din_ready`) writes P[i] for i=0..17. The accept of P[17] → LOAD_S.
- LOAD_S: `din_ready`=1. Words fill S0[0..255], then S1, S2 and S3 in that order. The accept of S3[255] → DONE.
- DONE: `din_ready`=0 and `done`=1 for exactly one cycle, then IDLE.
- Write order matches the standard Blowfish initialisation order: P-array, then S0..S3.
- Each accept increments `word_cnt`. `word_cnt` saturates at 1042 and holds its value in IDLE until the next `start`.
- `start` is ignored in LOAD_P, LOAD_S and DONE.
- `din_valid` low stalls the sequence indefinitely. No timeout.
- `p_we` and `s_we` are never both asserted in the same cycle. At most one bit of `s_we` is set.
- `rst` mid-load: the next state is IDLE and all outputs return to reset values. Partially written memory contents are left as they are, with no cleanup; the next `start` reloads from P[0].
- Reset values: `din_ready`, `p_we`, `s_we`, `busy` and `done` = 0. `p_addr`, `s_addr`, `p_wdata`, `s_wdata` and `word_cnt` = 0.

## Timing
- `start` sampled at edge N: `busy`=1 and `din_ready`=1 from cycle N+1.
- Handshake at edge M: the write strobe, address and data are registered and valid during cycle M+1 (latency 1). Back-to-back accepts give back-to-back strobes at full throughput.
- Last accept (S3[255]) at edge L:
  - `din_ready`=0 from cycle L+1.
  - `s_we`=4'b1000 with `s_addr`=255 during cycle L+1.
  - `done`=1 during cycle L+2.
  - `busy`=0 from cycle L+3.
- `busy` is high from the cycle after `start` through the `done` cycle, inclusive.
- Minimum load time is 1042 accept cycles plus 3 cycles of overhead.

## Structure
- Shared package `blowfish_pkg` holds:
  - `WORD_W`, `P_DEPTH`, `SBOX_DEPTH`, `NUM_SBOX`
  - `TOTAL_WORDS` = 1042
  - the loader state enum
- The S-box RAMs are instantiated outside this block; the loader only drives their write ports.
- One natural sub-module, `load_addr_gen`: a counter that holds the index within the current region and the S-box number. It outputs the next address, the one-hot select and the region-last flags (`p_last` at 17, `s_last` at S3[255]).

## Test plan
- Reset, then `start` with `din_valid` held high and words 0x243f6a88 first, 0x8979fb1b as the 18th → `p_we` at `p_addr` 0 with 0x243f6a88, `p_addr` 17 with 0x8979fb1b. The 19th word 0xd1310ba6 → `s_we`=0001, `s_addr`=0.
- Full 1042-word stream ending with 0x3ac372e6 → `s_we`=1000, `s_addr`=255, data 0x3ac372e6. `done` pulses 1 cycle later, `busy` drops the cycle after that, `word_cnt`=1042.
- `din_valid` toggled randomly over the whole load → no lost or duplicated writes. Write count per region is 18/256/256/256/256 and the data sequence matches the input.
- `start` pulsed during LOAD_S and again during DONE → ignored; the sequence and `word_cnt` are unaffected.
- `rst` asserted after 500 accepts → next cycle all outputs are 0 and the state is IDLE. A new `start` → the first write is at `p_addr` 0.
- S-box boundary: the accept of S0[255] followed by the next word → `s_we` 0001@255 then 0010@0 on consecutive cycles.
